// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the fetch PC,
// talks to instruction memory over a request/grant/response port with at most
// one request outstanding, and drives the IF/ID register seen by decode.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   stall        decode hazard: hold the IF/ID register
//   PCSel        EX-stage redirect (taken branch/jump); flushes IF/ID
//   PC_target    redirect address (low two bits ignored)
//   imem_req     request valid
//   imem_addr    request byte address (word aligned)
//   imem_gnt     request accepted this cycle
//   imem_rvalid  response valid (in order, >= 1 cycle after grant)
//   imem_rdata   response instruction word
//   PC_out       IF/ID program counter
//   Instruction  IF/ID instruction (NOP for bubbles/flushes)
//   valid_out    IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        PCSel,
  input  logic [31:0] PC_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] Instruction,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] req_pc, req_pc_n;
  logic [31:0] hold_pc, hold_pc_n;
  logic [31:0] hold_instr, hold_instr_n;
  logic        load;
  logic [31:0] load_pc;
  logic [31:0] load_instr;
  logic [31:0] target;

  // Masking keeps every bit of PC_target in use while forcing word alignment.
  assign target = PC_target & 32'hFFFF_FFFC;

  // Request side depends only on registered state, never on imem_gnt.
  assign imem_req  = (state == S_REQ);
  assign imem_addr = fetch_pc;

  always_comb begin
    state_n      = state;
    fetch_pc_n   = fetch_pc;
    req_pc_n     = req_pc;
    hold_pc_n    = hold_pc;
    hold_instr_n = hold_instr;
    load         = 1'b0;
    load_pc      = req_pc;
    load_instr   = imem_rdata;

    case (state)
      S_REQ: begin
        if (PCSel) begin
          fetch_pc_n = target;
          // A grant in the redirect cycle leaves a stale response to absorb.
          if (imem_gnt) state_n = S_DROP;
        end else if (imem_gnt) begin
          req_pc_n   = fetch_pc;
          fetch_pc_n = fetch_pc + 32'd4;
          state_n    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (PCSel) begin
          fetch_pc_n = target;
          state_n    = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          if (!stall) begin
            load    = 1'b1;
            state_n = S_REQ;
          end else begin
            hold_pc_n    = req_pc;
            hold_instr_n = imem_rdata;
            state_n      = S_HOLD;
          end
        end
      end
      S_DROP: begin
        // Still owe one response even if redirected again.
        if (PCSel) fetch_pc_n = target;
        else if (imem_rvalid) state_n = S_REQ;
      end
      S_HOLD: begin
        if (PCSel) begin
          fetch_pc_n   = target;
          hold_pc_n    = 32'h0;
          hold_instr_n = 32'h0;
          state_n      = S_REQ;
        end else if (!stall) begin
          load       = 1'b1;
          load_pc    = hold_pc;
          load_instr = hold_instr;
          state_n    = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_REQ;
      fetch_pc    <= RESET_PC;
      req_pc      <= 32'h0;
      hold_pc     <= 32'h0;
      hold_instr  <= 32'h0;
      PC_out      <= 32'h0;
      Instruction <= NOP;
      valid_out   <= 1'b0;
    end else begin
      state      <= state_n;
      fetch_pc   <= fetch_pc_n;
      req_pc     <= req_pc_n;
      hold_pc    <= hold_pc_n;
      hold_instr <= hold_instr_n;
      // Flush beats stall; stall beats load; otherwise insert a bubble.
      if (PCSel) begin
        Instruction <= NOP;
        valid_out   <= 1'b0;
      end else if (stall) begin
        Instruction <= Instruction;
        valid_out   <= valid_out;
      end else if (load) begin
        PC_out      <= load_pc;
        Instruction <= load_instr;
        valid_out   <= 1'b1;
      end else begin
        Instruction <= NOP;
        valid_out   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage. A small instruction-memory responder returns
// addr>>2 as the instruction after a programmable latency; a second instance
// with RESET_PC near the top of memory is driven by hand for wrap-around.
// -----------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] NOP_I = 32'h0000_0013;

  logic        clk;
  logic        reset, stall, PCSel;
  logic [31:0] PC_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] PC_out, Instruction;
  logic        valid_out;

  logic        w_reset, w_stall, w_PCSel;
  logic [31:0] w_PC_target;
  logic        w_req, w_gnt, w_rvalid;
  logic [31:0] w_addr, w_rdata;
  logic [31:0] w_PC_out, w_Instruction;
  logic        w_valid;

  int          total = 0;
  int          bad   = 0;

  logic        gnt_en;
  int          lat;
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  logic        cap_req;
  logic [31:0] cap_addr;

  logic [64:0] exp_ifid;
  logic [32:0] exp_req;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP(NOP_I)) dut (
    .clk(clk), .reset(reset), .stall(stall), .PCSel(PCSel),
    .PC_target(PC_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PC_out(PC_out), .Instruction(Instruction), .valid_out(valid_out)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP(NOP_I)) dut_w (
    .clk(clk), .reset(w_reset), .stall(w_stall), .PCSel(w_PCSel),
    .PC_target(w_PC_target), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(w_gnt), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .PC_out(w_PC_out), .Instruction(w_Instruction), .valid_out(w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive inputs mid-cycle, let the edge happen, update the
  // memory model, and come back to the falling edge for observation.
  task automatic step_cycle;
    imem_gnt    = gnt_en;
    imem_rvalid = pend && (pend_cnt == 0);
    imem_rdata  = imem_rvalid ? (pend_addr >> 2) : 32'hDEAD_BEEF;
    cap_req     = imem_req;
    cap_addr    = imem_addr;
    @(posedge clk);
    if (imem_rvalid) pend = 1'b0;
    else if (pend) pend_cnt = pend_cnt - 1;
    if (cap_req === 1'b1 && imem_gnt) begin
      pend      = 1'b1;
      pend_addr = cap_addr;
      pend_cnt  = lat - 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; gnt_en = 1'b0; stall = 1'b0; PCSel = 1'b0; lat = 1;
    step_cycle;
    step_cycle;
    total++;
    if ({valid_out, PC_out, Instruction} !== {1'b0, 32'h0, NOP_I}) begin
      bad++;
      $display("[TB] FAIL reset_ifid got=%h exp=%h", {valid_out, PC_out, Instruction}, {1'b0, 32'h0, NOP_I});
    end
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      bad++;
      $display("[TB] FAIL reset_req got=%h exp=%h", {imem_req, imem_addr}, {1'b1, 32'h0});
    end
    reset = 1'b0; gnt_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_req = {1'b1, 32'(4 * i)};
      total++;
      if ({imem_req, imem_addr} !== exp_req) begin
        bad++;
        $display("[TB] FAIL seq_req%0d got=%h exp=%h", i, {imem_req, imem_addr}, exp_req);
      end
      step_cycle;
      exp_ifid = {1'b0, 32'h0, NOP_I};
      total++;
      if ({valid_out, PC_out, Instruction} !== exp_ifid) begin
        bad++;
        $display("[TB] FAIL seq_bubble%0d got=%h exp=%h", i, {valid_out, PC_out, Instruction}, exp_ifid);
      end
      step_cycle;
      exp_ifid = {1'b1, 32'(4 * i), 32'(i)};
      total++;
      if ({valid_out, PC_out, Instruction} !== exp_ifid) begin
        bad++;
        $display("[TB] FAIL seq_valid%0d got=%h exp=%h", i, {valid_out, PC_out, Instruction}, exp_ifid);
      end
    end
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
      bad++;
      $display("[TB] FAIL seq_req2 got=%h exp=%h", {imem_req, imem_addr}, {1'b1, 32'h8});
    end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    step_cycle;
    total++;
    if ({valid_out, PC_out, Instruction, imem_req} !== {1'b1, 32'h4, 32'h1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL stall_grant got=%h exp=%h", {valid_out, PC_out, Instruction, imem_req}, {1'b1, 32'h4, 32'h1, 1'b0});
    end
    for (int c = 0; c < 3; c++) begin
      step_cycle;
      total++;
      if ({valid_out, PC_out, Instruction, imem_req} !== {1'b1, 32'h4, 32'h1, 1'b0}) begin
        bad++;
        $display("[TB] FAIL stall_hold%0d got=%h exp=%h", c, {valid_out, PC_out, Instruction, imem_req}, {1'b1, 32'h4, 32'h1, 1'b0});
      end
    end
    stall = 1'b0;
    step_cycle;
    total++;
    if ({valid_out, PC_out, Instruction} !== {1'b1, 32'h8, 32'h2}) begin
      bad++;
      $display("[TB] FAIL stall_release got=%h exp=%h", {valid_out, PC_out, Instruction}, {1'b1, 32'h8, 32'h2});
    end
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hC}) begin
      bad++;
      $display("[TB] FAIL stall_next_req got=%h exp=%h", {imem_req, imem_addr}, {1'b1, 32'hC});
    end
    step_cycle;
    step_cycle;
    total++;
    if ({valid_out, PC_out, Instruction} !== {1'b1, 32'hC, 32'h3}) begin
      bad++;
      $display("[TB] FAIL fetch_12 got=%h exp=%h", {valid_out, PC_out, Instruction}, {1'b1, 32'hC, 32'h3});
    end
  endtask

  task automatic test_redirect_wait;
    lat = 3;
    step_cycle;
    PCSel = 1'b1; PC_target = 32'h0000_0103;
    step_cycle;
    PCSel = 1'b0; PC_target = 32'h0;
    total++;
    if ({valid_out, PC_out, Instruction, imem_req} !== {1'b0, 32'hC, NOP_I, 1'b0}) begin
      bad++;
      $display("[TB] FAIL redir_flush got=%h exp=%h", {valid_out, PC_out, Instruction, imem_req}, {1'b0, 32'hC, NOP_I, 1'b0});
    end
    step_cycle;
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL redir_drop_req got=%b exp=0", imem_req);
    end
    step_cycle;
    total++;
    if ({valid_out, PC_out, Instruction} !== {1'b0, 32'hC, NOP_I}) begin
      bad++;
      $display("[TB] FAIL redir_discard got=%h exp=%h", {valid_out, PC_out, Instruction}, {1'b0, 32'hC, NOP_I});
    end
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
      bad++;
      $display("[TB] FAIL redir_target_req got=%h exp=%h", {imem_req, imem_addr}, {1'b1, 32'h100});
    end
    step_cycle;
    step_cycle;
    step_cycle;
    total++;
    if (valid_out !== 1'b0) begin
      bad++;
      $display("[TB] FAIL redir_wait_valid got=%b exp=0", valid_out);
    end
    step_cycle;
    total++;
    if ({valid_out, PC_out, Instruction} !== {1'b1, 32'h100, 32'h40}) begin
      bad++;
      $display("[TB] FAIL redir_arrive got=%h exp=%h", {valid_out, PC_out, Instruction}, {1'b1, 32'h100, 32'h40});
    end
  endtask

  task automatic test_collision;
    lat = 1;
    PCSel = 1'b1; stall = 1'b1; PC_target = 32'h0000_0200;
    step_cycle;
    PCSel = 1'b0; stall = 1'b0; PC_target = 32'h0;
    total++;
    if ({valid_out, PC_out, Instruction, imem_req} !== {1'b0, 32'h100, NOP_I, 1'b0}) begin
      bad++;
      $display("[TB] FAIL coll_flush got=%h exp=%h", {valid_out, PC_out, Instruction, imem_req}, {1'b0, 32'h100, NOP_I, 1'b0});
    end
    step_cycle;
    total++;
    if ({imem_req, imem_addr, valid_out} !== {1'b1, 32'h200, 1'b0}) begin
      bad++;
      $display("[TB] FAIL coll_after_drop got=%h exp=%h", {imem_req, imem_addr, valid_out}, {1'b1, 32'h200, 1'b0});
    end
    step_cycle;
    step_cycle;
    total++;
    if ({valid_out, PC_out, Instruction} !== {1'b1, 32'h200, 32'h80}) begin
      bad++;
      $display("[TB] FAIL coll_target got=%h exp=%h", {valid_out, PC_out, Instruction}, {1'b1, 32'h200, 32'h80});
    end
  endtask

  task automatic test_mid_reset;
    lat = 3;
    step_cycle;
    reset = 1'b1; gnt_en = 1'b0;
    step_cycle;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({valid_out, PC_out, Instruction, imem_req, imem_addr} !== {1'b0, 32'h0, NOP_I, 1'b1, 32'h0}) begin
        bad++;
        $display("[TB] FAIL mreset_idle%0d got=%h exp=%h", c, {valid_out, PC_out, Instruction, imem_req, imem_addr}, {1'b0, 32'h0, NOP_I, 1'b1, 32'h0});
      end
      step_cycle;
    end
    total++;
    if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h0}) begin
      bad++;
      $display("[TB] FAIL mreset_stale got=%h exp=%h", {valid_out, imem_req, imem_addr}, {1'b0, 1'b1, 32'h0});
    end
    gnt_en = 1'b1; lat = 1;
    step_cycle;
    step_cycle;
    total++;
    if ({valid_out, PC_out, Instruction} !== {1'b1, 32'h0, 32'h0}) begin
      bad++;
      $display("[TB] FAIL mreset_first got=%h exp=%h", {valid_out, PC_out, Instruction}, {1'b1, 32'h0, 32'h0});
    end
    gnt_en = 1'b0;
  endtask

  task automatic test_wrap;
    w_reset = 1'b1;
    step_cycle;
    w_reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if ({w_req, w_addr} !== {1'b1, 32'hFFFF_FFF8}) begin
        bad++;
        $display("[TB] FAIL wrap_backpressure%0d got=%h exp=%h", c, {w_req, w_addr}, {1'b1, 32'hFFFF_FFF8});
      end
      step_cycle;
    end
    w_gnt = 1'b1;
    step_cycle;
    w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h0000_00AA;
    step_cycle;
    w_rvalid = 1'b0;
    total++;
    if ({w_valid, w_PC_out, w_Instruction, w_req, w_addr} !== {1'b1, 32'hFFFF_FFF8, 32'hAA, 1'b1, 32'hFFFF_FFFC}) begin
      bad++;
      $display("[TB] FAIL wrap_first got=%h exp=%h", {w_valid, w_PC_out, w_Instruction, w_req, w_addr}, {1'b1, 32'hFFFF_FFF8, 32'hAA, 1'b1, 32'hFFFF_FFFC});
    end
    w_gnt = 1'b1;
    step_cycle;
    w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h0000_00BB;
    step_cycle;
    w_rvalid = 1'b0;
    total++;
    if ({w_valid, w_PC_out, w_Instruction, w_req, w_addr} !== {1'b1, 32'hFFFF_FFFC, 32'hBB, 1'b1, 32'h0}) begin
      bad++;
      $display("[TB] FAIL wrap_second got=%h exp=%h", {w_valid, w_PC_out, w_Instruction, w_req, w_addr}, {1'b1, 32'hFFFF_FFFC, 32'hBB, 1'b1, 32'h0});
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; PCSel = 1'b0; PC_target = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    gnt_en = 1'b0; lat = 1; pend = 1'b0; pend_addr = 32'h0; pend_cnt = 0;
    cap_req = 1'b0; cap_addr = 32'h0;
    w_reset = 1'b1; w_stall = 1'b0; w_PCSel = 1'b0; w_PC_target = 32'h0;
    w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
    @(negedge clk);
    $display("[TB] starting if_stage directed tests");
    test_reset;
    test_stall;
    test_redirect_wait;
    test_collision;
    test_mid_reset;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
